logic_unit_ctrl: RTL
====================

// Module: logic_unit_ctrl
// PURPOSE
//  Sequencer for the execute datapath: ula32, RegDesloc shifter, mux_shifter, mux_ALUOut.
//  Decodes 4-bit ALUOp into the datapath control wires.
//  Runs the multi-cycle shifter protocol (load, shift, hold).
//  Returns a one-cycle done pulse (Update_UC) to the main control unit, plus qualified overflow/illegal flags.
// PARAMETERS
//  SHIFT_LUI_AMT  16  shift amount selected when M_SHIFTER=1 (LUI path); informational, wired in mux_shifter
// PORTS
//  clk               in   1  system clock, all state on rising edge
//  reset             in   1  synchronous, active-low; reset==0 at a rising edge clears all state
//  start             in   1  request: execute ALUOp; sampled only in IDLE
//  ALUOp             in   4  operation code (table below); captured with start
//  Of                in   1  ula32 overflow flag (combinational)
//  ALU_control       out  3  ula32 function select
//  SHIFTER_control   out  3  RegDesloc cmd: 000 nop, 001 load, 010 sll, 011 srl, 100 sra
//  M_SHIFTER         out  1  0: shift amount = SHAMT; 1: shift amount = 16
//  M_ALUOut_control  out  3  000 ALU_out, 001 SHIFTER_out, 010 ALUSrcA, 011 EXTEND_out(Lt)
//  busy              out  1  high from the cycle after accepted start until done inclusive
//  Update_UC         out  1  done pulse, exactly one cycle per accepted start
//  OVERFLOW          out  1  Of qualified; valid only with Update_UC, ADD/SUB only
//  ILLEGAL           out  1  pulses with Update_UC when ALUOp=1111
// BEHAVIOUR
//  ALUOp table (op -> ALU_control / SHIFTER_control / M_ALUOut_control):
//   0000 ADD 001/000/000; 0001 SUB 010/000/000; 0010 AND 011/000/000
//   0011 XOR 100/000/000; 0100 NOT 101/000/000; 0101 INC 110/000/000
//   0110 SLT 111/000/011; 0111 PASSA 000/000/010
//   1000 SLL 1001 SRL 1010 SRA (M_SHIFTER=0); 1110 LUI = sll with M_SHIFTER=1
//   1011,1100,1101 reserved = treated as 1111
//   1111 ILLEGAL: no datapath action; controls stay at idle values
//  Outputs are registered.
//   Idle values: ALU_control=000, SHIFTER_control=000, M_SHIFTER=0, M_ALUOut_control=000.
//   busy=0, Update_UC=0, OVERFLOW=0, ILLEGAL=0.
//   Reset forces all outputs to these values.
//  States: IDLE, EXEC, SH_LOAD, SH_OP, SH_DONE.
//   Reset from any state, mid-operation included, returns to IDLE with idle outputs next cycle.
//   Any shifter content is discarded; no done pulse is issued.
//  IDLE + start=1 at edge k:
//   ALU/illegal op -> EXEC; shift op -> SH_LOAD.
//   ALUOp is latched into op_q; later ALUOp changes have no effect.
//  ALU ops, EXEC (cycle k+1): ALU controls driven, busy=1, Update_UC=1, -> IDLE.
//   OVERFLOW = Of & (op_q==ADD|SUB), sampled combinationally in this cycle.
//   Latency is 1 cycle.
//  Shift ops:
//   SH_LOAD (k+1): SHIFTER_control=001; M_SHIFTER and M_ALUOut_control=001 set.
//   SH_OP (k+2): shift code driven.
//   SH_DONE (k+3): SHIFTER_control=000, Update_UC=1, -> IDLE.
//   Latency is 3 cycles.
//   M_SHIFTER and M_ALUOut_control are held constant through SH_LOAD..SH_DONE.
//  Illegal op: EXEC with ILLEGAL=1, Update_UC=1, OVERFLOW=0.
//  start while busy: ignored, not queued.
//  start asserted in the done cycle: ignored. Back-to-back accept is possible the next cycle (IDLE).
//  Exactly one Update_UC pulse per accepted start; busy and Update_UC never high in IDLE.
// TESTING
//  Reset low 2 cycles mid SH_OP -> next cycle IDLE, all outputs 0, no Update_UC.
//  start, ALUOp=0000, Of=1 -> 1 cycle later ALU_control=001, Update_UC=1, OVERFLOW=1.
//   Same with ALUOp=0010 -> OVERFLOW=0.
//  start, ALUOp=1010 -> SHIFTER_control 001,100,000 on cycles k+1..k+3.
//   M_ALUOut_control=001 throughout; Update_UC only at k+3.
//  start, ALUOp=1110 -> M_SHIFTER=1, shift code 010; SHIFT 0x0000ABCD gives ALUOut=0xABCD0000.
//  start pulsed every cycle during SRL -> exactly one Update_UC per 4 cycles; no op accepted while busy.
//  ALUOp=0110 with A<B -> M_ALUOut_control=011, ALUOut=1; ALUOp=1111 -> ILLEGAL=1 with Update_UC.

Source files
------------

// File: rtl/logic_unit_ctrl.sv
// logic_unit_ctrl: execute-stage sequencer for ula32, RegDesloc, mux_shifter and mux_ALUOut.
// The sequencer decodes the 4-bit ALUOp into datapath selects. It runs the three-step shifter
// protocol (load, shift, hold). It returns a one-cycle Update_UC pulse per accepted start.
//
// Ports:
//   clk, reset         clock; synchronous active-low reset
//   start, ALUOp       request and operation code, sampled only while idle
//   Of                 ula32 overflow flag (combinational)
//   ALU_control        ula32 function select
//   SHIFTER_control    RegDesloc command (nop/load/sll/srl/sra)
//   M_SHIFTER          shift amount select (0: SHAMT, 1: SHIFT_LUI_AMT)
//   M_ALUOut_control   ALUOut source select
//   busy, Update_UC    in-flight flag and done pulse
//   OVERFLOW, ILLEGAL  flags qualified by the done cycle
module logic_unit_ctrl #(
  parameter int unsigned SHIFT_LUI_AMT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] ALUOp,
  input  logic       Of,
  output logic [2:0] ALU_control,
  output logic [2:0] SHIFTER_control,
  output logic       M_SHIFTER,
  output logic [2:0] M_ALUOut_control,
  output logic       busy,
  output logic       Update_UC,
  output logic       OVERFLOW,
  output logic       ILLEGAL
);

  // The amount itself is applied in mux_shifter; this block only raises M_SHIFTER for LUI.
  if (SHIFT_LUI_AMT != 16) begin : g_lui_amt_check
    $error("logic_unit_ctrl: LUI decode assumes a 16-bit shift amount");
  end

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpSlt = 4'b0110;
  localparam logic [3:0] OpPassA = 4'b0111;
  localparam logic [3:0] OpSll = 4'b1000;
  localparam logic [3:0] OpSrl = 4'b1001;
  localparam logic [3:0] OpSra = 4'b1010;
  localparam logic [3:0] OpLui = 4'b1110;
  localparam logic [3:0] OpIllegal = 4'b1111;

  typedef enum logic [2:0] {StIdle, StExec, StShLoad, StShOp, StShDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [3:0] op_norm;
  logic       op_is_shift;

  logic [2:0] alu_ctrl_q, alu_ctrl_d;
  logic [2:0] sh_ctrl_q, sh_ctrl_d;
  logic       m_sh_q, m_sh_d;
  logic [2:0] m_out_q, m_out_d;
  logic       busy_q, busy_d;
  logic       upd_q, upd_d;
  logic       ill_q, ill_d;
  logic [2:0] sh_code;

  // Reserved codes are folded onto the illegal code at capture, so later decode sees one value.
  always_comb begin
    op_norm = ALUOp;
    if (ALUOp == 4'b1011 || ALUOp == 4'b1100 || ALUOp == 4'b1101) begin
      op_norm = OpIllegal;
    end
    op_is_shift = (op_norm == OpSll) || (op_norm == OpSrl) || (op_norm == OpSra) ||
                  (op_norm == OpLui);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op_norm;
          state_d = op_is_shift ? StShLoad : StExec;
        end
      end
      StExec:   state_d = StIdle;
      StShLoad: state_d = StShOp;
      StShOp:   state_d = StShDone;
      StShDone: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    sh_code = 3'b000;
    case (op_q)
      OpSll, OpLui: sh_code = 3'b010;
      OpSrl:        sh_code = 3'b011;
      OpSra:        sh_code = 3'b100;
      default:      sh_code = 3'b000;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the state they describe.
  always_comb begin
    alu_ctrl_d = 3'b000;
    sh_ctrl_d  = 3'b000;
    m_sh_d     = 1'b0;
    m_out_d    = 3'b000;
    busy_d     = 1'b0;
    upd_d      = 1'b0;
    ill_d      = 1'b0;
    unique case (state_d)
      StExec: begin
        busy_d = 1'b1;
        upd_d  = 1'b1;
        case (op_d)
          OpAdd:   alu_ctrl_d = 3'b001;
          OpSub:   alu_ctrl_d = 3'b010;
          4'b0010: alu_ctrl_d = 3'b011;
          4'b0011: alu_ctrl_d = 3'b100;
          4'b0100: alu_ctrl_d = 3'b101;
          4'b0101: alu_ctrl_d = 3'b110;
          OpSlt: begin
            alu_ctrl_d = 3'b111;
            m_out_d    = 3'b011;
          end
          OpPassA: m_out_d = 3'b010;
          default: ill_d = 1'b1;
        endcase
      end
      StShLoad, StShOp, StShDone: begin
        busy_d  = 1'b1;
        m_sh_d  = (op_d == OpLui);
        m_out_d = 3'b001;
        if (state_d == StShLoad) begin
          sh_ctrl_d = 3'b001;
        end else if (state_d == StShOp) begin
          sh_ctrl_d = sh_code;
        end else begin
          upd_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      op_q       <= 4'b0000;
      alu_ctrl_q <= 3'b000;
      sh_ctrl_q  <= 3'b000;
      m_sh_q     <= 1'b0;
      m_out_q    <= 3'b000;
      busy_q     <= 1'b0;
      upd_q      <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      alu_ctrl_q <= alu_ctrl_d;
      sh_ctrl_q  <= sh_ctrl_d;
      m_sh_q     <= m_sh_d;
      m_out_q    <= m_out_d;
      busy_q     <= busy_d;
      upd_q      <= upd_d;
      ill_q      <= ill_d;
    end
  end

  assign ALU_control      = alu_ctrl_q;
  assign SHIFTER_control  = sh_ctrl_q;
  assign M_SHIFTER        = m_sh_q;
  assign M_ALUOut_control = m_out_q;
  assign busy             = busy_q;
  assign Update_UC        = upd_q;
  assign ILLEGAL          = ill_q;
  // Of comes straight from ula32 in the same cycle, so this flag is qualified combinationally.
  assign OVERFLOW = Of && (state_q == StExec) && (op_q == OpAdd || op_q == OpSub);

endmodule
